// File: rtl/bank_timing_pkg.sv
// Shared types for the per-bank DRAM timing array: command encoding, bank states,
// violation reasons, and the per-state dwell time lookup.
package bank_timing_pkg;

    typedef enum logic [2:0] {
        CMD_ACT = 3'd0,
        CMD_RD  = 3'd1,
        CMD_RDA = 3'd2,
        CMD_WR  = 3'd3,
        CMD_WRA = 3'd4,
        CMD_PR  = 3'd5,
        CMD_PRA = 3'd6,
        CMD_REF = 3'd7
    } bank_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_ACTIVATING  = 4'd1,
        ST_ACTIVE      = 4'd2,
        ST_READING     = 4'd3,
        ST_WRITING     = 4'd4,
        ST_RTP_WAIT    = 4'd5,
        ST_PRECHARGING = 4'd6,
        ST_REFRESHING  = 4'd7
    } bank_state_e;

    typedef enum logic [2:0] {
        V_NONE     = 3'd0,
        V_NOT_IDLE = 3'd1,
        V_NOT_OPEN = 3'd2,
        V_BUSY     = 3'd3,
        V_REF_BUSY = 3'd4
    } bank_viol_e;

    // Number of cycles a bank dwells in a timed state; untimed states report 1.
    function automatic int state_cycles(input bank_state_e s, input int bl, input int t_rcd,
                                        input int t_rp, input int t_wr, input int t_rtp,
                                        input int t_rfc);
        case (s)
            ST_ACTIVATING:  return t_rcd;
            ST_READING:     return bl;
            ST_WRITING:     return bl + t_wr;
            ST_RTP_WAIT:    return t_rtp;
            ST_PRECHARGING: return t_rp;
            ST_REFRESHING:  return t_rfc;
            default:        return 1;
        endcase
    endfunction

endpackage

// File: rtl/bank_fsm.sv
// One bank's timing state machine: state register, dwell down-counter and the
// auto-precharge flag that chains a burst into precharge.
module bank_fsm
    import bank_timing_pkg::*;
#(
    parameter int BL    = 8,
    parameter int T_RCD = 15,
    parameter int T_RP  = 16,
    parameter int T_WR  = 14,
    parameter int T_RTP = 7,
    parameter int T_RFC = 34,
    parameter int CW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit_i,
    input  bank_cmd_e   cmd_i,
    input  logic        pra_i,
    input  logic        ref_i,
    output bank_state_e state_o,
    output logic        busy_o,
    output logic        illegal_o
);

    function automatic logic [CW-1:0] ld(input bank_state_e s);
        int n;
        n = state_cycles(s, BL, T_RCD, T_RP, T_WR, T_RTP, T_RFC) - 1;
        return n[CW-1:0];
    endfunction

    bank_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ap_q, ap_d;
    logic          busy;

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_ACTIVE);
    assign busy_o  = busy;
    assign state_o = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ap_d      = ap_q;
        illegal_o = 1'b0;
        if (busy) begin
            // Timed states accept nothing; a command on the expiry cycle is judged
            // against the state being left.
            illegal_o = hit_i;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                case (state_q)
                    ST_ACTIVATING: state_d = ST_ACTIVE;
                    ST_READING: begin
                        if (ap_q) begin
                            state_d = ST_RTP_WAIT;
                            cnt_d   = ld(ST_RTP_WAIT);
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end
                    ST_WRITING: begin
                        if (ap_q) begin
                            state_d = ST_PRECHARGING;
                            cnt_d   = ld(ST_PRECHARGING);
                            ap_d    = 1'b0;
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end
                    ST_RTP_WAIT: begin
                        state_d = ST_PRECHARGING;
                        cnt_d   = ld(ST_PRECHARGING);
                        ap_d    = 1'b0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (ref_i) begin
            state_d = ST_REFRESHING;
            cnt_d   = ld(ST_REFRESHING);
            ap_d    = 1'b0;
        end else if (pra_i) begin
            if (state_q == ST_ACTIVE) begin
                state_d = ST_PRECHARGING;
                cnt_d   = ld(ST_PRECHARGING);
                ap_d    = 1'b0;
            end
        end else if (hit_i) begin
            if (state_q == ST_IDLE) begin
                case (cmd_i)
                    CMD_ACT: begin
                        state_d = ST_ACTIVATING;
                        cnt_d   = ld(ST_ACTIVATING);
                    end
                    CMD_PR:  ;
                    default: illegal_o = 1'b1;
                endcase
            end else begin
                case (cmd_i)
                    CMD_RD, CMD_RDA: begin
                        state_d = ST_READING;
                        cnt_d   = ld(ST_READING);
                        ap_d    = (cmd_i == CMD_RDA);
                    end
                    CMD_WR, CMD_WRA: begin
                        state_d = ST_WRITING;
                        cnt_d   = ld(ST_WRITING);
                        ap_d    = (cmd_i == CMD_WRA);
                    end
                    CMD_PR: begin
                        state_d = ST_PRECHARGING;
                        cnt_d   = ld(ST_PRECHARGING);
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ap_q    <= ap_d;
        end
    end

endmodule

// File: rtl/bank_timing_array.sv
// Array of per-bank timing FSMs with address decode, all-bank PRA/REF legality
// checks and a registered violation report.
module bank_timing_array
    import bank_timing_pkg::*;
#(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int BL      = 8,
    parameter int T_RCD   = 15,
    parameter int T_RP    = 16,
    parameter int T_WR    = 14,
    parameter int T_RTP   = 7,
    parameter int T_RFC   = 34,
    parameter int CW      = 8,
    localparam int BGW    = (BGWIDTH > 0) ? BGWIDTH : 1,
    localparam int NB     = 2 ** (BGWIDTH + BAWIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic [BGW-1:0]    bg,
    input  logic [BAWIDTH-1:0] ba,
    output logic [NB*4-1:0]   bank_state,
    output logic [NB-1:0]     bank_busy,
    output logic              all_idle,
    output logic              violation,
    output logic [2:0]        viol_code
);

    localparam int IW = BGWIDTH + BAWIDTH;

    bank_cmd_e   cmd_e;
    logic [IW-1:0] bank_idx;
    logic        is_global;
    logic [NB-1:0] hit_vec;
    logic [NB-1:0] illegal_vec;
    logic        any_busy;
    logic        pra_ok;
    logic        ref_ok;
    logic        viol_now;
    bank_viol_e  code_now;
    logic        violation_q;
    bank_viol_e  viol_code_q;

    assign cmd_e     = bank_cmd_e'(cmd);
    assign is_global = (cmd_e == CMD_PRA) || (cmd_e == CMD_REF);

    generate
        if (BGWIDTH == 0) begin : g_single_group
            logic unused_bg;
            assign unused_bg = ^bg;
            assign bank_idx  = ba;
        end else begin : g_multi_group
            assign bank_idx = {bg, ba};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            bank_state_e st;
            assign hit_vec[gi] = cmd_valid && !is_global && (bank_idx == IW'(gi));
            bank_fsm #(
                .BL(BL), .T_RCD(T_RCD), .T_RP(T_RP), .T_WR(T_WR),
                .T_RTP(T_RTP), .T_RFC(T_RFC), .CW(CW)
            ) u_fsm (
                .clk       (clk),
                .reset     (reset),
                .hit_i     (hit_vec[gi]),
                .cmd_i     (cmd_e),
                .pra_i     (pra_ok),
                .ref_i     (ref_ok),
                .state_o   (st),
                .busy_o    (bank_busy[gi]),
                .illegal_o (illegal_vec[gi])
            );
            assign bank_state[gi*4 +: 4] = st;
        end
    endgenerate

    // IDLE encodes as zero, so an all-zero state vector means every bank is idle.
    assign all_idle = ~|bank_state;
    assign any_busy = |bank_busy;
    assign pra_ok   = cmd_valid && (cmd_e == CMD_PRA) && !any_busy;
    assign ref_ok   = cmd_valid && (cmd_e == CMD_REF) && all_idle;

    always_comb begin
        viol_now = 1'b0;
        code_now = V_NONE;
        if (cmd_valid) begin
            case (cmd_e)
                CMD_PRA: begin
                    viol_now = any_busy;
                    code_now = V_BUSY;
                end
                CMD_REF: begin
                    viol_now = !all_idle;
                    code_now = V_REF_BUSY;
                end
                CMD_ACT: begin
                    viol_now = |illegal_vec;
                    code_now = V_NOT_IDLE;
                end
                CMD_PR: begin
                    viol_now = |illegal_vec;
                    code_now = V_BUSY;
                end
                default: begin
                    viol_now = |illegal_vec;
                    code_now = V_NOT_OPEN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            violation_q <= 1'b0;
            viol_code_q <= V_NONE;
        end else begin
            violation_q <= viol_now;
            if (viol_now) begin
                viol_code_q <= code_now;
            end
        end
    end

    assign violation = violation_q;
    assign viol_code = viol_code_q;

endmodule

// File: doc/bank_timing_array.md
# bank_timing_array

Parametrised per-bank DRAM timing state machine array for the memory emulator. It tracks every bank in every bank group through activate, read/write burst, write recovery, precharge and refresh, with each state held for its configured cycle count. It replaces hard-wired bank FSMs with timing parameters, an encoded command bus, auto-precharge sequencing, all-bank precharge/refresh, and illegal-command detection. It sits between the command decoder and the data-path/row-buffer logic, which consume the per-bank state and busy flags.

## Interface
- BGWIDTH, 2, bank-group address width; 0 means DDR3, a single group.
- BAWIDTH, 2, bank address width.
- BL, 8, burst length in cycles.
- T_RCD, 15, ACT to ACTIVE, in cycles; ≥1.
- T_RP, 16, precharge time, in cycles; ≥1.
- T_WR, 14, write recovery after the burst, in cycles.
- T_RTP, 7, read to precharge for RDA, in cycles.
- T_RFC, 34, refresh time, in cycles; ≥1.
- CW, 8, counter width; must hold max(T_*, BL+T_WR) - 1.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command strobe.
- cmd  in  3  bank_cmd_e: ACT, RD, RDA, WR, WRA, PR, PRA, REF.
- bg  in  max(BGWIDTH,1)  target bank group; ignored when BGWIDTH=0.
- ba  in  BAWIDTH  target bank.
- bank_state  out  NB×4  packed bank_state_e per bank; NB = 2^BGWIDTH × 2^BAWIDTH; index = bg×2^BAWIDTH+ba.
- bank_busy  out  NB  1 when the bank is in any timed state.
- all_idle  out  1  all banks IDLE.
- violation  out  1  one-cycle pulse for an illegal command.
- viol_code  out  3  bank_viol_e reason; held until the next violation.

## Operation
- States: IDLE, ACTIVATING, ACTIVE, READING, WRITING, RTP_WAIT, PRECHARGING, REFRESHING.
- IDLE + ACT → ACTIVATING for T_RCD cycles → ACTIVE.
- ACTIVE + RD → READING for BL cycles → ACTIVE.
- ACTIVE + RDA → READING for BL → RTP_WAIT for T_RTP → PRECHARGING.
- ACTIVE + WR → WRITING for BL+T_WR → ACTIVE.
- ACTIVE + WRA → WRITING for BL+T_WR → PRECHARGING.
- ACTIVE + PR → PRECHARGING for T_RP → IDLE.
- IDLE + PR: legal no-op.
- PRA: every ACTIVE bank → PRECHARGING; IDLE banks are unchanged. Illegal if any bank is busy.
- REF: legal only when all_idle. All banks → REFRESHING for T_RFC cycles → IDLE.
- Each bank's down-counter loads N-1 on state entry. The state advances on the cycle the counter reads 0.
- An auto-precharge flag is latched at RDA/WRA and cleared on entry to PRECHARGING.
- Illegal command: state is unchanged. violation=1 next cycle.
- viol_code values:
  - V_NOT_IDLE: ACT to a non-IDLE bank.
  - V_NOT_OPEN: RD/RD*/WR* to a non-ACTIVE bank.
  - V_BUSY: PR to a busy bank, or PRA while any bank is busy.
  - V_REF_BUSY: REF while not all_idle.
- cmd_valid=0: counting only.

## Timing
- A command sampled at edge N is visible on bank_state/bank_busy after edge N, in cycle N+1.
- ACT at N: ACTIVATING during N+1..N+T_RCD; ACTIVE at N+T_RCD+1. A command accepted at N+T_RCD+1 is legal.
- WRA at N: WRITING for BL+T_WR cycles, then PRECHARGING for T_RP cycles, then IDLE at N+BL+T_WR+T_RP+1.
- RDA at N: IDLE at N+BL+T_RTP+T_RP+1.
- REF at N: all banks IDLE at N+T_RFC+1.
- A command that arrives on the cycle a bank's counter hits 0 is judged against the pre-transition state; it is rejected unless that state is legal for the command.
- violation is registered: it asserts in cycle N+1 for a command at N.
- Reset, including mid-burst or mid-refresh: all banks IDLE, counters 0, violation=0, viol_code=V_NONE. Effective after the reset edge.
- Outputs after reset: bank_state all IDLE (0), bank_busy=0, all_idle=1.

## Structure
- bank_timing_pkg holds:
  - bank_cmd_e, bank_state_e (4 bits, IDLE=0), bank_viol_e (V_NONE=0).
  - A function returning the load value per state.
- Sub-module bank_fsm: one bank's state register, counter and auto-precharge flag. Inputs: hit, cmd, pra, ref. Outputs: state, busy, illegal.
- Top level: generate NB instances, address decode, the PRA/REF all-idle/any-busy checks, and the violation register.

## Test plan
- Reset then ACT bg=1 ba=1 at cycle 4 → bank 5 ACTIVATING cycles 5–19, ACTIVE at 20; all other banks IDLE.
- WR at 20 → WRITING 21–42; PR at 43 → PRECHARGING 44–59, IDLE at 60.
- ACT bank 5, then WRA at the first ACTIVE cycle N → IDLE exactly at N+39. RDA variant → IDLE at N+32.
- RD to IDLE bank 0 → violation=1 one cycle later, viol_code=V_NOT_OPEN, state unchanged. REF with bank 5 ACTIVE → V_REF_BUSY.
- Banks 0 and 5 ACTIVE, PRA → both PRECHARGING for 16 cycles. Then REF → all REFRESHING 34 cycles, then all_idle=1.
- Reset asserted mid-REFRESHING → next cycle all IDLE, bank_busy=0. Repeat with BGWIDTH=0 (DDR3, 4 banks).
